// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a valid/ack byte handshake.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN (8E1 frame).
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | line idle, waiting for rxs=0
//  S_START  | half-bit wait, confirm start bit still low (else glitch)
//  S_DATA   | sample DATA_BITS data bits at mid-bit, LSB first
//  S_PARITY | sample even-parity bit (only with UART_RX_PARITY_EN)
//  S_STOP   | sample stop bit, then report byte or errors
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ack_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_meta;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bad;
    logic                 tick;
    logic                 stop_sample;
    logic                 stop_good;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    assign tick = (cnt == '0);

    // Next-state logic; every sample point is the terminal count of the bit timer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rxs) state_nxt = S_START;
            S_START: if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA: begin
                if (tick && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (tick) state_nxt = S_STOP;
`endif
            S_STOP:  if (tick) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame-completion strobes decoded from the current state.
    always_comb begin
        stop_sample = 1'b0;
        stop_good   = 1'b0;
        if (state == S_STOP && tick) begin
            stop_sample = 1'b1;
            stop_good   = rxs && !parity_bad;
        end
    end

    // Bit timer (down-counter reloaded at each sample), bit counter and shifter.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (state == S_IDLE) begin
                cnt     <= HALF_LOAD;
                bit_cnt <= '0;
            end else if (tick) begin
                cnt <= BIT_LOAD;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == S_DATA && tick) begin
                shift   <= {rxs, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)                      parity_bad <= 1'b0;
        else if (state == S_IDLE)          parity_bad <= 1'b0;
        else if (state == S_PARITY && tick) parity_bad <= rxs ^ (^shift);
    end
`else
    assign parity_bad = 1'b0;
`endif

    // Output register: byte handshake, overrun and error pulses one cycle after the stop sample.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            frame_err_o  <= stop_sample && !rxs;
            parity_err_o <= stop_sample && parity_bad;
            overrun_o    <= 1'b0;
            if (stop_good) begin
                if (!data_valid_o || data_ack_i) begin
                    data_o       <= shift;
                    data_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (data_ack_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with an expected-byte scoreboard and a negedge monitor.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Offsets from the negedge that drops the start bit: two synchroniser cycles,
    // half a bit, then data (+parity) and stop bits.
    localparam int STOP_OFS = 2 + CPB / 2 + (DB + 1 + PAR) * CPB;
    localparam int LOAD_OFS = STOP_OFS + 1;

    logic          clk;
    logic          rst_n;
    logic          rx;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          data_ack;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .rx_i         (rx),
        .data_o       (data),
        .data_valid_o (data_valid),
        .data_ack_i   (data_ack),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .overrun_o    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cyc   = 0;
    int last_load   = 0;
    int load_cnt    = 0;
    int n_frame     = 0;
    int n_par       = 0;
    int n_ovr       = 0;
    logic ack_taken = 1'b0;
    logic valid_q   = 1'b0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] exp_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        ack_taken <= data_ack && data_valid;
    end

    // A load is a rising valid, or valid still high right after an accepted ack.
    always @(negedge clk) begin
        if (frame_err)  n_frame++;
        if (parity_err) n_par++;
        if (overrun)    n_ovr++;
        if (data_valid && (!valid_q || ack_taken)) begin
            load_cnt++;
            last_load = cyc;
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("sb_data", 32'(data), 32'(exp_b));
            end
        end
        valid_q = data_valid;
    end

    // Drives one whole frame starting at a negedge; optionally acks in the load cycle.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input logic par_bit, input bit ack_at_load);
        logic [11:0] fr;
        int nb;
        fr    = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < DB; i++) fr[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
        fr[DB+1] = par_bit;
        fr[DB+2] = stop_bit;
        nb       = DB + 3;
`else
        fr[DB+1] = stop_bit;
        fr[DB+2] = par_bit;   // parity slot is not transmitted in 8N1
        nb       = DB + 2;
`endif
        start_cyc = cyc;
        for (int i = 0; i < nb * CPB; i++) begin
            rx       = fr[i / CPB];
            data_ack = ack_at_load && (i == STOP_OFS);
            @(negedge clk);
        end
        rx       = 1'b1;
        data_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int l0;

    initial begin
        rx       = 1'b1;
        data_ack = 1'b0;
        rst_n    = 1'b0;
        idle(3);
        check("rst_data",   32'(data),       32'd0);
        check("rst_valid",  32'(data_valid), 32'd0);
        check("rst_ferr",   32'(frame_err),  32'd0);
        check("rst_perr",   32'(parity_err), 32'd0);
        check("rst_ovr",    32'(overrun),    32'd0);
        rst_n = 1'b1;
        idle(4);

        // Basic frame, latency and ack.
        l0 = load_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
        check("t1_loads",   32'(load_cnt - l0),         32'd1);
        check("t1_latency", 32'(last_load - start_cyc), 32'(LOAD_OFS));
        check("t1_valid",   32'(data_valid),            32'd1);
        check("t1_data",    32'(data),                  32'hA5);
        ack_pulse();
        check("t1_ack_clr", 32'(data_valid),            32'd0);
        idle(CPB);

        // Short glitch on the line.
        l0 = load_cnt;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(3 * CPB);
        check("t2_loads", 32'(load_cnt - l0), 32'd0);
        check("t2_valid", 32'(data_valid),    32'd0);
        check("t2_ferr",  32'(n_frame),       32'd0);
        check("t2_perr",  32'(n_par),         32'd0);

        // Framing error, then a good frame.
        l0 = load_cnt;
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
        idle(2 * CPB);
        check("t3_ferr",  32'(n_frame),       32'd1);
        check("t3_valid", 32'(data_valid),    32'd0);
        check("t3_loads", 32'(load_cnt - l0), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, ^8'h81, 1'b0);
        check("t3_data",  32'(data),          32'h81);
        check("t3_loads2", 32'(load_cnt - l0), 32'd1);
        ack_pulse();
        idle(CPB);

        // Overrun: second byte dropped while first is unacked.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
        check("t4_ovr",   32'(n_ovr),      32'd1);
        check("t4_data",  32'(data),       32'h11);
        check("t4_valid", 32'(data_valid), 32'd1);
        ack_pulse();
        check("t4_ack_clr", 32'(data_valid), 32'd0);
        ack_pulse();
        check("t4_stray_ack", 32'(data_valid), 32'd0);

        // Ack in the load cycle: new byte replaces the old one without overrun.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b1);
        check("t4b_ovr",   32'(n_ovr),      32'd1);
        check("t4b_data",  32'(data),       32'h22);
        check("t4b_valid", 32'(data_valid), 32'd1);
        ack_pulse();
        check("t4b_ack_clr", 32'(data_valid), 32'd0);
        idle(CPB);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        l0 = load_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("t5_ok_loads",   32'(load_cnt - l0),         32'd1);
        check("t5_ok_latency", 32'(last_load - start_cyc), 32'(LOAD_OFS));
        check("t5_ok_data",    32'(data),                  32'h07);
        ack_pulse();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(CPB);
        check("t5_perr",      32'(n_par),          32'd1);
        check("t5_bad_loads", 32'(load_cnt - l0),  32'd1);
        check("t5_bad_valid", 32'(data_valid),     32'd0);
`endif

        // Reset in the middle of a frame.
        exp_q.push_back(8'h44);
        send_frame(8'h44, 1'b1, ^8'h44, 1'b0);
        check("t6_pre_valid", 32'(data_valid), 32'd1);
        l0 = load_cnt;
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(3 * CPB);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(data_valid), 32'd0);
        check("t6_rst_data",  32'(data),       32'd0);
        check("t6_rst_pulses", 32'({frame_err, parity_err, overrun}), 32'd0);
        @(negedge clk);
        idle(2 * CPB);
        rst_n = 1'b1;
        idle(4);
        check("t6_no_partial", 32'(load_cnt - l0), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
        check("t6_data",  32'(data),           32'h5A);
        check("t6_loads", 32'(load_cnt - l0),  32'd1);
        ack_pulse();
        idle(CPB);

        check("end_sb_empty", 32'(exp_q.size()), 32'd0);
        check("end_ferr",     32'(n_frame),      32'd1);
        check("end_perr",     32'(n_par),        32'(PAR));
        check("end_ovr",      32'(n_ovr),        32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
